icache_responder: RTL

//  Direct-mapped, read-only instruction cache: the responder end of the datapath's

---
 rtl/icache_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with one-word blocks, filled over iREN/iwait/iload.
// Optional hit/miss statistics counters are built only when ICACHE_STATS_EN is defined.
module icache_responder #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [29:0]       miss_word_q, miss_word_d;
    logic [TAGW-1:0]   tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IDXW-1:0]   lookup_idx;
    logic [TAGW-1:0]   lookup_tag;
    logic [IDXW-1:0]   miss_idx;
    logic [TAGW-1:0]   miss_tag;
    logic              hit;
    logic              fill_we;
    logic              unused_byte_offset;

    assign unused_byte_offset = ^imemaddr[1:0];

    assign lookup_idx = imemaddr[IDXW+1:2];
    assign lookup_tag = imemaddr[31:IDXW+2];
    assign miss_idx   = miss_word_q[IDXW-1:0];
    assign miss_tag   = miss_word_q[29:IDXW];

    assign hit      = imemREN && valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign ihit     = hit && (state_q == IDLE);
    assign imemload = data_q[lookup_idx];
    assign iaddr    = {miss_word_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_word_d = miss_word_q;
        fill_we     = 1'b0;
        iREN        = 1'b0;
        case (state_q)
            IDLE: begin
                if (imemREN && !hit) begin
                    state_d     = FETCH;
                    miss_word_d = imemaddr[31:2];
                end
            end
            FETCH: begin
                iREN = 1'b1;
                // The fill always targets the latched miss address, whatever the datapath does now.
                if (!iwait) begin
                    fill_we           = 1'b1;
                    valid_d[miss_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_word_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_word_q <= miss_word_d;
        end
    end

    // Tag and data arrays carry no reset; a response landing on a reset edge is dropped.
    always_ff @(posedge CLK) begin
        if (fill_we && !RST) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'b0, ihit};
        miss_cnt_d = miss_cnt_q + {31'b0, (state_q == IDLE) && (state_d == FETCH)};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
